mem_access: RTL and testbench



---
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MIPS memory-access stage: drives the data-memory req/ack handshake, stalls while
// an access is outstanding, and registers the stage result as the MEM/WB register.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_whilo,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_sel,
    output logic [31:0] d_wdata,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        wb_addr_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic        is_load, is_store, sign_ext;
    logic        sz_byte, sz_half, sz_word;
    logic        misaligned, legal, addr_err, load_done;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        case (mem_op)
            4'd1: begin is_load  = 1'b1; sz_byte = 1'b1; sign_ext = 1'b1; end
            4'd2: begin is_load  = 1'b1; sz_byte = 1'b1; end
            4'd3: begin is_load  = 1'b1; sz_half = 1'b1; sign_ext = 1'b1; end
            4'd4: begin is_load  = 1'b1; sz_half = 1'b1; end
            4'd5: begin is_load  = 1'b1; sz_word = 1'b1; end
            4'd6: begin is_store = 1'b1; sz_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; sz_half = 1'b1; end
            4'd8: begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (sz_half && mem_addr[0]) || (sz_word && (mem_addr[1:0] != 2'b00));
    assign addr_err   = (is_load || is_store) && misaligned;
    assign legal      = (is_load || is_store) && !misaligned;

    // Gated by rst so the request drops the instant reset asserts, before the FSM clears.
    assign d_req     = legal && !rst;
    assign d_we      = is_store;
    assign d_addr    = {mem_addr[31:2], 2'b00};
    assign stallreq  = d_req && !d_ack;
    assign load_done = d_req && d_ack && is_load;

    always_comb begin
        d_sel   = '0;
        d_wdata = mem_sdata;
        if (sz_byte) begin
            d_sel   = 4'b1000 >> mem_addr[1:0];
            d_wdata = {4{mem_sdata[7:0]}};
        end else if (sz_half) begin
            d_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
            d_wdata = {2{mem_sdata[15:0]}};
        end else if (sz_word) begin
            d_sel   = 4'b1111;
        end
    end

    always_comb begin
        case (mem_addr[1:0])
            2'd0:    byte_val = d_rdata[31:24];
            2'd1:    byte_val = d_rdata[23:16];
            2'd2:    byte_val = d_rdata[15:8];
            default: byte_val = d_rdata[7:0];
        endcase
        half_val  = mem_addr[1] ? d_rdata[15:0] : d_rdata[31:16];
        load_data = d_rdata;
        if (sz_byte) begin
            load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
        end else if (sz_half) begin
            load_data = {{16{sign_ext & half_val[15]}}, half_val};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (d_req && !d_ack) state_next = WAIT;
            WAIT: if (d_ack || !d_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd       <= '0;
            wb_wreg     <= 1'b0;
            wb_wdata    <= '0;
            wb_hi       <= '0;
            wb_lo       <= '0;
            wb_whilo    <= 1'b0;
            wb_addr_err <= 1'b0;
        end else if (stallreq) begin
            wb_wreg     <= 1'b0;
            wb_whilo    <= 1'b0;
            wb_addr_err <= 1'b0;
        end else begin
            wb_wd       <= mem_wd;
            wb_wreg     <= mem_wreg && !addr_err;
            wb_wdata    <= load_done ? load_data : mem_wdata;
            wb_hi       <= mem_hi;
            wb_lo       <= mem_lo;
            wb_whilo    <= mem_whilo && !addr_err;
            wb_addr_err <= addr_err;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table with a write-back scoreboard, plus a reset-mid-access sequence.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_sdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic        wb_whilo, wb_addr_err;

    int checks   = 0;
    int failures = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .stallreq(stallreq),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_addr_err(wb_addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        int unsigned waits;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_bus;
        logic [31:0] e_wb_wdata;
        logic        e_wreg;
        logic        e_whilo;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        err;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wb_t e, got;
        mem_op    = v.op;
        mem_addr  = v.addr;
        mem_sdata = v.sdata;
        mem_wd    = v.wd;
        mem_wreg  = v.wreg;
        mem_wdata = v.wdata;
        mem_hi    = v.hi;
        mem_lo    = v.lo;
        mem_whilo = v.whilo;
        e = '{v.wd, v.e_wreg, v.e_wb_wdata, v.hi, v.lo, v.e_whilo, v.e_err};
        sb.push_back(e);
        for (int unsigned c = 0; c <= v.waits; c++) begin
            d_ack   = (c == v.waits);
            d_rdata = (c == v.waits) ? v.rdata : 32'hDEADBEEF;
            #1;
            chk($sformatf("v%0d.c%0d d_req", idx, c), d_req, v.e_req);
            chk($sformatf("v%0d.c%0d stallreq", idx, c), stallreq, v.e_req && (c < v.waits));
            if (v.e_req) begin
                chk($sformatf("v%0d.c%0d d_addr", idx, c), d_addr, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d.c%0d d_sel", idx, c), d_sel, v.e_sel);
                chk($sformatf("v%0d.c%0d d_we", idx, c), d_we, v.e_we);
                if (v.e_we) chk($sformatf("v%0d.c%0d d_wdata", idx, c), d_wdata, v.e_bus);
            end
            @(posedge clk);
            #1;
            if (c < v.waits) begin
                chk($sformatf("v%0d.c%0d bubble wreg", idx, c), wb_wreg, 1'b0);
                chk($sformatf("v%0d.c%0d bubble whilo", idx, c), wb_whilo, 1'b0);
                chk($sformatf("v%0d.c%0d bubble err", idx, c), wb_addr_err, 1'b0);
            end else if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL v%0d scoreboard empty actual=0 required=1", idx);
            end else begin
                got = sb.pop_front();
                chk($sformatf("v%0d wb_wd", idx), wb_wd, got.wd);
                chk($sformatf("v%0d wb_wreg", idx), wb_wreg, got.wreg);
                chk($sformatf("v%0d wb_wdata", idx), wb_wdata, got.wdata);
                chk($sformatf("v%0d wb_hi", idx), wb_hi, got.hi);
                chk($sformatf("v%0d wb_lo", idx), wb_lo, got.lo);
                chk($sformatf("v%0d wb_whilo", idx), wb_whilo, got.whilo);
                chk($sformatf("v%0d wb_addr_err", idx), wb_addr_err, got.err);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_hi = '0; mem_lo = '0;
        mem_whilo = 1'b0; mem_op = '0; mem_addr = '0; mem_sdata = '0;
        d_ack = 1'b0; d_rdata = '0;

        //          op  addr          sdata          rdata          wd  wr data          hi     lo     hl wt req we sel      bus            wb_wdata       wr hl err
        vecs.push_back('{4'd0,  32'h0,   32'h0,        32'hFFFFFFFF, 5'd5,  1, 32'h1234, 32'hA, 32'hB, 1, 0, 0, 0, 4'b0000, 32'h0,        32'h1234,     1, 1, 0});
        vecs.push_back('{4'd1,  32'h103, 32'h0,        32'h000000F0, 5'd3,  1, 32'hDEAD, 32'h1, 32'h2, 0, 2, 1, 0, 4'b0001, 32'h0,        32'hFFFFFFF0, 1, 0, 0});
        vecs.push_back('{4'd4,  32'h200, 32'h0,        32'h8001FFFF, 5'd4,  1, 32'h1,    32'h3, 32'h4, 0, 0, 1, 0, 4'b1100, 32'h0,        32'h00008001, 1, 0, 0});
        vecs.push_back('{4'd6,  32'h301, 32'hAB,       32'h0,        5'd0,  0, 32'h55,   32'h5, 32'h6, 0, 0, 1, 1, 4'b0100, 32'hABABABAB, 32'h55,       0, 0, 0});
        vecs.push_back('{4'd5,  32'h102, 32'h0,        32'h99,       5'd7,  1, 32'h77,   32'h7, 32'h8, 1, 0, 0, 0, 4'b0000, 32'h0,        32'h77,       0, 0, 1});
        vecs.push_back('{4'd3,  32'h402, 32'h0,        32'h12348765, 5'd8,  1, 32'h0,    32'h9, 32'hA, 0, 1, 1, 0, 4'b0011, 32'h0,        32'hFFFF8765, 1, 0, 0});
        vecs.push_back('{4'd5,  32'h500, 32'h0,        32'hCAFEBABE, 5'd9,  1, 32'h0,    32'h0, 32'h0, 0, 3, 1, 0, 4'b1111, 32'h0,        32'hCAFEBABE, 1, 0, 0});
        vecs.push_back('{4'd7,  32'h602, 32'hFFFFBEEF, 32'h0,        5'd0,  0, 32'h66,   32'h0, 32'h0, 0, 1, 1, 1, 4'b0011, 32'hBEEFBEEF, 32'h66,       0, 0, 0});
        vecs.push_back('{4'd2,  32'h701, 32'h0,        32'h11A23344, 5'd10, 1, 32'h0,    32'h0, 32'h0, 0, 0, 1, 0, 4'b0100, 32'h0,        32'h000000A2, 1, 0, 0});
        vecs.push_back('{4'd8,  32'h800, 32'h13579BDF, 32'h0,        5'd0,  0, 32'h88,   32'h0, 32'h0, 0, 0, 1, 1, 4'b1111, 32'h13579BDF, 32'h88,       0, 0, 0});
        vecs.push_back('{4'd12, 32'h3,   32'h0,        32'h5,        5'd11, 1, 32'h99,   32'h1, 32'h1, 1, 0, 0, 0, 4'b0000, 32'h0,        32'h99,       1, 1, 0});
        vecs.push_back('{4'd7,  32'h901, 32'h1,        32'h0,        5'd12, 0, 32'hAA,   32'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'hAA,       0, 0, 1});
        vecs.push_back('{4'd1,  32'h100, 32'h0,        32'h7F000000, 5'd13, 1, 32'h0,    32'h0, 32'h0, 0, 0, 1, 0, 4'b1000, 32'h0,        32'h0000007F, 1, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset wb_wd", wb_wd, 5'd0);
        chk("reset wb_wreg", wb_wreg, 1'b0);
        chk("reset wb_wdata", wb_wdata, 32'h0);
        chk("reset wb_whilo", wb_whilo, 1'b0);
        chk("reset wb_addr_err", wb_addr_err, 1'b0);
        chk("reset d_req", d_req, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("scoreboard drained", sb.size(), 0);

        // Abandon an in-flight load with reset; a late ack must not be consumed.
        mem_op = 4'd5; mem_addr = 32'hA00; mem_wd = 5'd6; mem_wreg = 1'b1;
        mem_wdata = 32'h31; mem_hi = 32'h0; mem_lo = 32'h0; mem_whilo = 1'b0;
        d_ack = 1'b0; d_rdata = 32'h0;
        #1;
        chk("rstseq stall before", stallreq, 1'b1);
        @(posedge clk);
        #1;
        chk("rstseq bubble wreg", wb_wreg, 1'b0);
        chk("rstseq held wdata", wb_wdata, 32'h0000007F);
        rst = 1'b1;
        #1;
        chk("rstseq d_req", d_req, 1'b0);
        chk("rstseq stallreq", stallreq, 1'b0);
        chk("rstseq wb_wd", wb_wd, 5'd0);
        chk("rstseq wb_wdata", wb_wdata, 32'h0);
        chk("rstseq wb_hi", wb_hi, 32'h0);
        chk("rstseq wb_lo", wb_lo, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_op = 4'd0; mem_wd = 5'd2; mem_wreg = 1'b1; mem_wdata = 32'h42;
        d_ack = 1'b1; d_rdata = 32'hBAD;
        #1;
        chk("late ack d_req", d_req, 1'b0);
        chk("late ack stallreq", stallreq, 1'b0);
        @(posedge clk);
        #1;
        chk("late ack wb_wdata", wb_wdata, 32'h42);
        chk("late ack wb_wd", wb_wd, 5'd2);
        chk("late ack wb_wreg", wb_wreg, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
